// File: rtl/lsu_pkg.sv
// Shared load/store unit types: size codes, FSM states and byte-count helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package lsu_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_D  = 3'b011,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101,
        SZ_WU = 3'b110
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } lsu_state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size_lo);
        return 4'd1 << size_lo;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and data-memory bus signals of the load/store unit.
// Latency: none (wiring only).
// Backpressure: req via req_ready_o, bus beats via mem_gnt_i; response has none.
interface lsu_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_wr_i;
    logic [2:0]        req_size_i;
    logic [AW-1:0]     req_addr_i;
    logic [XLEN-1:0]   req_wdata_i;
    logic              rsp_valid_o;
    logic [XLEN-1:0]   rsp_rdata_o;
    logic              rsp_err_o;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic              mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;
    logic              mem_err_i;

    modport slave (
        input  req_valid_i, req_wr_i, req_size_i, req_addr_i, req_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_size_i, req_addr_i, req_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_align.sv
// Lane alignment: two-beat byte enables and shifted store data; extended load data.
// Latency: combinational.
// Backpressure: none.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]                  st_size,
    input  logic [$clog2(XLEN/8)-1:0]   st_off,
    input  logic [XLEN-1:0]             st_wdata,
    output logic [XLEN/4-1:0]           be2,
    output logic [2*XLEN-1:0]           wdata2,
    input  logic [2:0]                  ld_size,
    input  logic [$clog2(XLEN/8)-1:0]   ld_off,
    input  logic [2*XLEN-1:0]           rbuf,
    output logic [XLEN-1:0]             rdata
);
    localparam int NB = XLEN / 8;

    logic [3:0]      st_n;
    logic [3:0]      ld_n;
    logic [2*NB-1:0] mask;
    logic [XLEN-1:0] shifted;
    logic            fill;
    int              top;

    always_comb begin
        st_n = size_bytes(st_size);
        mask = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            mask[i] = (i < int'(st_n));
        end
        be2    = mask << st_off;
        wdata2 = {{XLEN{1'b0}}, st_wdata} << {st_off, 3'b000};
    end

    // A doubleword on a 32-bit datapath never reaches here legally; clamp so the top index stays in range.
    always_comb begin
        ld_n    = size_bytes(ld_size[1:0]);
        shifted = XLEN'(rbuf >> {ld_off, 3'b000});
        top     = (int'(ld_n) * 8 > XLEN) ? XLEN - 1 : int'(ld_n) * 8 - 1;
        fill    = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == top) fill = shifted[i];
        end
        fill = fill & ~ld_size[2];
        for (int i = 0; i < XLEN; i++) begin
            rdata[i] = (i <= top) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: splits boundary-straddling accesses into two bus beats, returns extended load data.
// Latency: 3 cycles accept-to-response aligned, 5 when split, 1 for illegal requests (zero-wait bus).
// Backpressure: req_ready_o only in IDLE; bus stalls on mem_gnt_i/mem_rvalid_i; response is never stalled.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic clk_i,
    input  logic rst_n_i,
    lsu_if.slave bus
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    lsu_state_t        state, state_nx;
    logic              wr_q, err_q;
    logic [2:0]        size_q;
    logic [OW-1:0]     off_q;
    logic [AW-1:0]     base_q;
    logic [2*NB-1:0]   be2_q, be2_d;
    logic [2*XLEN-1:0] wdata2_q, wdata2_d, rbuf_q;
    logic [XLEN-1:0]   rdata_ext;
    logic              accept, illegal, split;

    assign accept  = (state == IDLE) && bus.req_valid_i;
    assign illegal = (bus.req_size_i == 3'b111)
                   || (bus.req_wr_i && bus.req_size_i[2])
                   || ((XLEN == 32) && (bus.req_size_i == SZ_D || bus.req_size_i == SZ_WU));
    assign split   = |be2_q[2*NB-1:NB];

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_size  (bus.req_size_i[1:0]),
        .st_off   (bus.req_addr_i[OW-1:0]),
        .st_wdata (bus.req_wdata_i),
        .be2      (be2_d),
        .wdata2   (wdata2_d),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .rbuf     (rbuf_q),
        .rdata    (rdata_ext)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= '0;
            off_q    <= '0;
            base_q   <= '0;
            be2_q    <= '0;
            wdata2_q <= '0;
            rbuf_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wr_q     <= bus.req_wr_i;
                err_q    <= illegal;
                size_q   <= bus.req_size_i;
                off_q    <= bus.req_addr_i[OW-1:0];
                base_q   <= {bus.req_addr_i[AW-1:OW], {OW{1'b0}}};
                be2_q    <= illegal ? '0 : be2_d;
                wdata2_q <= bus.req_wr_i ? wdata2_d : '0;
                rbuf_q   <= '0;
            end else if (state == WAIT0 && bus.mem_rvalid_i) begin
                rbuf_q[XLEN-1:0] <= bus.mem_rdata_i;
                err_q            <= bus.mem_err_i;
            end else if (state == WAIT1 && bus.mem_rvalid_i) begin
                rbuf_q[2*XLEN-1:XLEN] <= bus.mem_rdata_i;
                err_q                 <= err_q | bus.mem_err_i;
            end
        end
    end

    always_comb begin
        state_nx        = state;
        bus.req_ready_o = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_be_o    = '0;
        bus.mem_wdata_o = '0;
        bus.rsp_valid_o = 1'b0;
        bus.rsp_err_o   = 1'b0;
        bus.rsp_rdata_o = '0;
        case (state)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) state_nx = illegal ? RESP : REQ0;
            end
            REQ0: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = wr_q;
                bus.mem_addr_o  = base_q;
                bus.mem_be_o    = be2_q[NB-1:0];
                bus.mem_wdata_o = wdata2_q[XLEN-1:0];
                if (bus.mem_gnt_i) state_nx = WAIT0;
            end
            // A faulting first beat ends the access; the second half is never fetched.
            WAIT0: if (bus.mem_rvalid_i) state_nx = (bus.mem_err_i || !split) ? RESP : REQ1;
            REQ1: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = wr_q;
                bus.mem_addr_o  = base_q + AW'(NB);
                bus.mem_be_o    = be2_q[2*NB-1:NB];
                bus.mem_wdata_o = wdata2_q[2*XLEN-1:XLEN];
                if (bus.mem_gnt_i) state_nx = WAIT1;
            end
            WAIT1: if (bus.mem_rvalid_i) state_nx = RESP;
            RESP: begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_err_o   = err_q;
                bus.rsp_rdata_o = (wr_q || err_q) ? '0 : rdata_ext;
                state_nx        = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
